// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: session FSM that drives the cardhandling database block.
// Optional CARD_LOCK_MEM_EN keeps locked-out cards refused until reset.
module atm_session_ctrl #(
    parameter int card_width     = 3,
    parameter int password_width = 4,
    parameter int balance_width  = 20,
    parameter int users_num      = 7,
    parameter int max_attempts   = 3,
    parameter int timeout_cycles = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      card_inserted,
    input  logic [card_width-1:0]     card_in,
    input  logic                      psw_valid,
    input  logic [password_width-1:0] psw_in,
    input  logic                      op_valid,
    input  logic [1:0]                op_sel,
    input  logic [balance_width-1:0]  amount,
    input  logic [balance_width-1:0]  balance,
    input  logic                      wrong_psw,
    output logic [card_width-1:0]     card_number,
    output logic [password_width-1:0] password_input,
    output logic                      op_done,
    output logic [balance_width-1:0]  updated_balance,
    output logic [balance_width-1:0]  balance_out,
    output logic                      txn_ok,
    output logic                      insufficient,
    output logic                      overflow,
    output logic                      invalid_card,
    output logic                      locked,
    output logic                      eject_card,
    output logic                      busy
);

    localparam int TW = $clog2(timeout_cycles + 1);
    localparam int AW = $clog2(max_attempts + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PSW,
        S_CHECK,
        S_EVAL,
        S_MENU,
        S_WRITE
    } state_t;

    state_t state, state_d;

    logic [TW-1:0]             timer, timer_d;
    logic [AW-1:0]             attempts, attempts_d;
    logic [balance_width-1:0]  bal_reg, bal_d;
    logic [card_width-1:0]     card_d;
    logic [password_width-1:0] psw_d;
    logic [balance_width-1:0]  upd_d, bal_out_d;
    logic                      op_done_d, txn_d, insuf_d, ovf_d;
    logic                      inv_d, locked_d, eject_d;
    logic                      lock_set;
    logic                      card_ok, card_locked, timeout;
    logic [balance_width:0]    dep_sum;
    logic [balance_width-1:0]  wd_val;

    assign card_ok = 32'(card_in) < 32'(users_num);
    assign timeout = timer == TW'(timeout_cycles - 1);
    assign dep_sum = {1'b0, bal_reg} + {1'b0, amount};
    assign wd_val  = bal_reg - amount;
    assign busy    = state != S_IDLE;

`ifdef CARD_LOCK_MEM_EN
    logic [users_num-1:0] lock_mem;

    assign card_locked = card_ok && lock_mem[card_in];

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_mem <= '0;
        end else if (lock_set) begin
            lock_mem[card_number] <= 1'b1;
        end
    end
`else
    assign card_locked = 1'b0;
`endif

    always_comb begin
        state_d    = state;
        timer_d    = '0;
        attempts_d = attempts;
        bal_d      = bal_reg;
        card_d     = card_number;
        psw_d      = password_input;
        upd_d      = updated_balance;
        bal_out_d  = balance_out;
        op_done_d  = 1'b0;
        txn_d      = 1'b0;
        insuf_d    = 1'b0;
        ovf_d      = 1'b0;
        inv_d      = 1'b0;
        locked_d   = 1'b0;
        eject_d    = 1'b0;
        lock_set   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (card_inserted) begin
                    card_d = card_in;
                    if (!card_ok) begin
                        inv_d   = 1'b1;
                        eject_d = 1'b1;
                    end else if (card_locked) begin
                        locked_d = 1'b1;
                        eject_d  = 1'b1;
                    end else begin
                        attempts_d = '0;
                        state_d    = S_WAIT_PSW;
                    end
                end
            end
            S_WAIT_PSW: begin
                // a PIN arriving on the timeout cycle still counts
                if (psw_valid) begin
                    psw_d   = psw_in;
                    state_d = S_CHECK;
                end else if (timeout) begin
                    eject_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            S_CHECK: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (wrong_psw) begin
                    attempts_d = attempts + AW'(1);
                    if (attempts_d == AW'(max_attempts)) begin
                        locked_d   = 1'b1;
                        eject_d    = 1'b1;
                        lock_set   = 1'b1;
                        attempts_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_WAIT_PSW;
                    end
                end else begin
                    bal_d      = balance;
                    attempts_d = '0;
                    state_d    = S_MENU;
                end
            end
            S_MENU: begin
                if (op_valid) begin
                    unique case (op_sel)
                        2'd0: begin
                            bal_out_d = bal_reg;
                            txn_d     = 1'b1;
                        end
                        2'd1: begin
                            if (amount > bal_reg) begin
                                insuf_d = 1'b1;
                            end else begin
                                upd_d     = wd_val;
                                op_done_d = 1'b1;
                                state_d   = S_WRITE;
                            end
                        end
                        2'd2: begin
                            if (dep_sum[balance_width]) begin
                                ovf_d = 1'b1;
                            end else begin
                                upd_d     = dep_sum[balance_width-1:0];
                                op_done_d = 1'b1;
                                state_d   = S_WRITE;
                            end
                        end
                        2'd3: begin
                            eject_d = 1'b1;
                            state_d = S_IDLE;
                        end
                    endcase
                end else if (timeout) begin
                    eject_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            S_WRITE: begin
                // op_done is high during this state; commit afterwards
                bal_d     = updated_balance;
                bal_out_d = updated_balance;
                txn_d     = 1'b1;
                state_d   = S_MENU;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            timer           <= '0;
            attempts        <= '0;
            bal_reg         <= '0;
            card_number     <= '0;
            password_input  <= '0;
            updated_balance <= '0;
            balance_out     <= '0;
            op_done         <= 1'b0;
            txn_ok          <= 1'b0;
            insufficient    <= 1'b0;
            overflow        <= 1'b0;
            invalid_card    <= 1'b0;
            locked          <= 1'b0;
            eject_card      <= 1'b0;
        end else begin
            state           <= state_d;
            timer           <= timer_d;
            attempts        <= attempts_d;
            bal_reg         <= bal_d;
            card_number     <= card_d;
            password_input  <= psw_d;
            updated_balance <= upd_d;
            balance_out     <= bal_out_d;
            op_done         <= op_done_d;
            txn_ok          <= txn_d;
            insufficient    <= insuf_d;
            overflow        <= ovf_d;
            invalid_card    <= inv_d;
            locked          <= locked_d;
            eject_card      <= eject_d;
        end
    end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Transaction controller that acts as the initiator of the cardhandling interface.
- Captures card number and PIN from the keypad front end and presents them to cardhandling. Evaluates the returned wrong_psw/balance, then runs an inquiry, withdraw or deposit.
- Writes the new balance back with a one-cycle op_done strobe and ejects the card.
- Sits between the user I/O front end and the cardhandling database block.

Parameters:
- card_width, 3, card number width
- password_width, 4, PIN width
- balance_width, 20, balance/amount width
- users_num, 7, valid card numbers are 0..users_num-1
- max_attempts, 3, wrong PINs allowed before lockout
- timeout_cycles, 1000, idle cycles in WAIT_PSW/MENU before forced eject

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- card_inserted  in  1  pulse: card_in valid
- card_in  in  card_width  card number from reader
- psw_valid  in  1  pulse: psw_in valid
- psw_in  in  password_width  PIN entered
- op_valid  in  1  pulse: op_sel/amount valid
- op_sel  in  2  0=inquiry, 1=withdraw, 2=deposit, 3=exit
- amount  in  balance_width  transaction amount
- balance  in  balance_width  from cardhandling
- wrong_psw  in  1  from cardhandling
- card_number  out  card_width  to cardhandling
- password_input  out  password_width  to cardhandling
- op_done  out  1  write-back strobe to cardhandling
- updated_balance  out  balance_width  write-back value
- balance_out  out  balance_width  balance shown to user
- txn_ok  out  1  pulse: transaction completed
- insufficient  out  1  pulse: withdraw amount > balance
- overflow  out  1  pulse: deposit would exceed 2^balance_width-1
- invalid_card  out  1  pulse: card_in >= users_num
- locked  out  1  pulse: attempts exhausted
- eject_card  out  1  pulse: session ended
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, attempts=0, timer=0. All outputs 0.
- Abort rule: rst in any state aborts the session. No op_done is issued.
- IDLE:
  - On card_inserted, latch card_in into card_number.
  - If card_in >= users_num: invalid_card=1 and eject_card=1 for 1 cycle, stay IDLE.
  - Otherwise go to WAIT_PSW.
- WAIT_PSW: on psw_valid, latch psw_in into password_input (op_done=0), go to CHECK.
- CHECK: one wait cycle. cardhandling registers wrong_psw/balance one cycle after inputs are presented.
- EVAL: sample wrong_psw.
  - wrong_psw=1: attempts+1. If the new count = max_attempts, locked=1 and eject_card=1 for 1 cycle, go to IDLE. Else go to WAIT_PSW.
  - wrong_psw=0: latch balance into bal_reg, attempts=0, go to MENU.
- MENU: on op_valid, dispatch on op_sel.
  - inquiry: balance_out=bal_reg, txn_ok pulse, stay MENU.
  - withdraw, amount>bal_reg: insufficient pulse, stay MENU.
  - withdraw, otherwise: new=bal_reg-amount, go to WRITE.
  - deposit: compute the sum at balance_width+1 bits. Carry set gives an overflow pulse and stays in MENU; no write. Else new=sum, go to WRITE.
  - exit: eject_card pulse, go to IDLE.
  - amount=0 is legal and performs a write of the unchanged balance.
- WRITE: for exactly 1 cycle, op_done=1, updated_balance=new, card_number held. Then bal_reg=new, balance_out=new, txn_ok pulse, go to MENU.
- Timer:
  - Counts while in WAIT_PSW or MENU. It clears on any accepted pulse and on every state change.
  - When timer reaches timeout_cycles-1: eject_card pulse, go to IDLE.
- Ignored inputs:
  - card_inserted is ignored when not in IDLE.
  - psw_valid is ignored outside WAIT_PSW.
  - op_valid is ignored outside MENU.
- Simultaneous events: if psw_valid and the timeout coincide, psw_valid wins.
- Pulse width: every pulse output is high for exactly 1 cycle.
- password_input and card_number hold their values until the next latch.

Optional Feature:
- Macro: CARD_LOCK_MEM_EN.
- Defined:
  - A users_num-bit locked_cards register is set for a card when its lockout occurs.
  - A later card_inserted for a set card gives locked pulse + eject_card pulse in IDLE, with no PIN phase.
  - The register is cleared only by rst.
- Undefined: lockout ends only the current session, and the card may retry on reinsertion.

Test Plan:
- rst=1 mid-MENU with op_valid=1 -> next cycle busy=0, op_done=0, all outputs 0.
- card_in=7 inserted -> invalid_card=1, eject_card=1 in the same pulse cycle; state stays IDLE.
- Card 2, wrong PIN 3 times (wrong_psw=1 each) -> locked and eject_card on the 3rd EVAL. With CARD_LOCK_MEM_EN, reinserting card 2 -> immediate locked.
- Card 1, correct PIN (balance=500), withdraw 200 -> op_done=1 with updated_balance=300 for 1 cycle, then txn_ok=1, balance_out=300.
- Balance=1048000, deposit 1000 -> overflow=1, op_done never asserted. Withdraw 1048001 -> insufficient=1.
- Correct PIN, then no input for timeout_cycles cycles -> eject_card pulse, busy=0.
